// File: rtl/tl_ul_reg_bridge.sv
// TL-UL slave endpoint that turns one buffered A request into one req/ack register transfer and one D response.
// Optional REQ-state watchdog enabled with `define TL_REG_BRIDGE_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
//
//   state | meaning
//   IDLE  | a_ready high, waiting for an A request
//   REQ   | register request pending, waiting for reg_ack (or timeout)
//   RESP  | D response valid, waiting for d_ready
module tl_ul_reg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [1:0]  auto_in_a_bits_size,
    input  logic [2:0]  auto_in_a_bits_source,
    input  logic [30:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_size,
    output logic [2:0]  auto_in_d_bits_source,
    output logic [63:0] auto_in_d_bits_data,
    output logic        reg_req_valid,
    output logic        reg_req_write,
    output logic [30:0] reg_req_addr,
    output logic [63:0] reg_req_wdata,
    output logic [7:0]  reg_req_wmask,
    input  logic        reg_ack,
    input  logic [63:0] reg_rdata,
    output logic        err_timeout
);

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
        $error("tl_ul_reg_bridge: TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [1:0] {IDLE, REQ, RESP} stateT;

    stateT       state, stateNext;
    logic [2:0]  opcodeQ;
    logic [1:0]  sizeQ;
    logic [2:0]  sourceQ;
    logic [30:0] addrQ;
    logic [7:0]  maskQ;
    logic [63:0] wdataQ;
    logic [63:0] dDataQ;
    logic        aFire, ackTake, timeoutHit, inSupported, isReadQ;

    assign inSupported = (auto_in_a_bits_opcode == OpPutFull) ||
                         (auto_in_a_bits_opcode == OpPutPartial) ||
                         (auto_in_a_bits_opcode == OpGet);
    assign isReadQ = (opcodeQ == OpGet);

`ifdef TL_REG_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] timeoutCnt;
    logic        errTimeoutQ;
    assign timeoutHit  = (state == REQ) && !reg_ack && (timeoutCnt == TimeoutLast);
    assign err_timeout = errTimeoutQ;
`else
    assign timeoutHit  = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        aFire     = 1'b0;
        ackTake   = 1'b0;
        case (state)
            IDLE: if (auto_in_a_valid) begin
                aFire     = 1'b1;
                stateNext = inSupported ? REQ : RESP;
            end
            REQ: begin
                if (reg_ack) begin
                    ackTake   = 1'b1;
                    stateNext = RESP;
                end else if (timeoutHit) begin
                    stateNext = RESP;
                end
            end
            RESP: if (auto_in_d_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            opcodeQ <= '0;
            sizeQ   <= '0;
            sourceQ <= '0;
            addrQ   <= '0;
            maskQ   <= '0;
            wdataQ  <= '0;
            dDataQ  <= '0;
        end else if (aFire) begin
            opcodeQ <= auto_in_a_bits_opcode;
            sizeQ   <= auto_in_a_bits_size;
            sourceQ <= auto_in_a_bits_source;
            addrQ   <= auto_in_a_bits_address;
            maskQ   <= (auto_in_a_bits_opcode == OpGet) ? 8'h00 : auto_in_a_bits_mask;
            wdataQ  <= auto_in_a_bits_data;
            dDataQ  <= '0;
        end else if (ackTake) begin
            dDataQ  <= isReadQ ? reg_rdata : 64'd0;
        end else if (timeoutHit) begin
            // Reads that never complete return all ones so software can spot the hole.
            dDataQ  <= isReadQ ? {64{1'b1}} : 64'd0;
        end
    end

`ifdef TL_REG_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            timeoutCnt  <= '0;
            errTimeoutQ <= 1'b0;
        end else begin
            if (aFire)                            timeoutCnt <= '0;
            else if (state == REQ && !reg_ack)    timeoutCnt <= timeoutCnt + 16'd1;
            if (timeoutHit)                       errTimeoutQ <= 1'b1;
        end
    end
`endif

    assign auto_in_a_ready       = (state == IDLE);
    assign auto_in_d_valid       = (state == RESP);
    assign auto_in_d_bits_opcode = {2'b00, isReadQ};
    assign auto_in_d_bits_size   = sizeQ;
    assign auto_in_d_bits_source = sourceQ;
    assign auto_in_d_bits_data   = dDataQ;
    assign reg_req_valid         = (state == REQ);
    assign reg_req_write         = (state == REQ) && !isReadQ;
    assign reg_req_addr          = addrQ;
    assign reg_req_wdata         = wdataQ;
    assign reg_req_wmask         = maskQ;

endmodule

// File: tb/tb_tl_ul_reg_bridge.sv
// Directed bench for tl_ul_reg_bridge: scoreboard of expected D beats, register-bus responder inline.
module tb_tl_ul_reg_bridge;

`ifdef TL_REG_BRIDGE_TIMEOUT_EN
    localparam int unsigned TimeoutCycles = 4;
`else
    localparam int unsigned TimeoutCycles = 256;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        aReady, aValid;
    logic [2:0]  aOpcode;
    logic [1:0]  aSize;
    logic [2:0]  aSource;
    logic [30:0] aAddress;
    logic [7:0]  aMask;
    logic [63:0] aData;
    logic        dReady, dValid;
    logic [2:0]  dOpcode;
    logic [1:0]  dSize;
    logic [2:0]  dSource;
    logic [63:0] dData;
    logic        reqValid, reqWrite;
    logic [30:0] reqAddr;
    logic [63:0] reqWdata;
    logic [7:0]  reqWmask;
    logic        regAck;
    logic [63:0] regRdata;
    logic        errTimeout;

    tl_ul_reg_bridge #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
        .clock(clock), .reset(reset),
        .auto_in_a_ready(aReady), .auto_in_a_valid(aValid),
        .auto_in_a_bits_opcode(aOpcode), .auto_in_a_bits_size(aSize),
        .auto_in_a_bits_source(aSource), .auto_in_a_bits_address(aAddress),
        .auto_in_a_bits_mask(aMask), .auto_in_a_bits_data(aData),
        .auto_in_d_ready(dReady), .auto_in_d_valid(dValid),
        .auto_in_d_bits_opcode(dOpcode), .auto_in_d_bits_size(dSize),
        .auto_in_d_bits_source(dSource), .auto_in_d_bits_data(dData),
        .reg_req_valid(reqValid), .reg_req_write(reqWrite), .reg_req_addr(reqAddr),
        .reg_req_wdata(reqWdata), .reg_req_wmask(reqWmask),
        .reg_ack(regAck), .reg_rdata(regRdata), .err_timeout(errTimeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [2:0]  src;
        logic [63:0] data;
    } dExpT;

    dExpT expQ[$];
    int   nAssert = 0;
    int   nFail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expectResp(input int dHold);
        int   waitCnt;
        dExpT e;
        waitCnt = 0;
        while (dValid !== 1'b1 && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        check("d_valid_arrives", dValid, 1'b1);
        check("scoreboard_has_entry", 64'(expQ.size() > 0), 64'd1);
        if (dValid !== 1'b1 || expQ.size() == 0) return;
        e = expQ.pop_front();
        for (int i = 0; i <= dHold; i++) begin
            check("d_valid_hold", dValid, 1'b1);
            check("a_ready_low_in_resp", aReady, 1'b0);
            check("d_opcode", dOpcode, e.op);
            check("d_size", dSize, e.size);
            check("d_source", dSource, e.src);
            check("d_data", dData, e.data);
            if (i == dHold) dReady = 1'b1;
            tick();
        end
        dReady = 1'b0;
        check("d_valid_after_fire", dValid, 1'b0);
        check("a_ready_after_fire", aReady, 1'b1);
    endtask

    task automatic doTxn(input logic [2:0] op, input logic [1:0] size, input logic [2:0] src,
                         input logic [30:0] addr, input logic [7:0] mask, input logic [63:0] wdata,
                         input int ackDelay, input logic [63:0] rdata, input int dHold);
        dExpT e;
        aValid = 1'b1; aOpcode = op; aSize = size; aSource = src;
        aAddress = addr; aMask = mask; aData = wdata;
        check("a_ready_idle", aReady, 1'b1);
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.size = size;
        e.src  = src;
        e.data = (op == 3'd4) ? rdata : 64'd0;
        expQ.push_back(e);
        tick();
        aValid = 1'b0; aData = {$urandom, $urandom}; aMask = 8'($urandom); aAddress = 31'($urandom);
        if (op == 3'd0 || op == 3'd1 || op == 3'd4) begin
            for (int i = 0; i <= ackDelay; i++) begin
                check("req_valid", reqValid, 1'b1);
                check("req_write", reqWrite, (op != 3'd4));
                check("req_addr", reqAddr, addr);
                check("req_wmask", reqWmask, (op == 3'd4) ? 8'h00 : mask);
                check("req_wdata", reqWdata, wdata);
                check("a_ready_low_in_req", aReady, 1'b0);
                check("d_valid_low_in_req", dValid, 1'b0);
                regRdata = (i == ackDelay) ? rdata : {$urandom, $urandom};
                regAck   = (i == ackDelay);
                tick();
            end
            regAck = 1'b0; regRdata = {$urandom, $urandom};
        end else begin
            check("no_req_unsupported", reqValid, 1'b0);
        end
        check("d_valid_latency", dValid, 1'b1);
        expectResp(dHold);
    endtask

    initial begin
        reset = 1'b1; aValid = 1'b0; aOpcode = '0; aSize = '0; aSource = '0;
        aAddress = '0; aMask = '0; aData = '0; dReady = 1'b0; regAck = 1'b0; regRdata = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_a_ready", aReady, 1'b1);
        check("rst_d_valid", dValid, 1'b0);
        check("rst_req_valid", reqValid, 1'b0);
        check("rst_req_write", reqWrite, 1'b0);
        check("rst_req_addr", reqAddr, 31'd0);
        check("rst_req_wdata", reqWdata, 64'd0);
        check("rst_req_wmask", reqWmask, 8'd0);
        check("rst_d_opcode", dOpcode, 3'd0);
        check("rst_d_size", dSize, 2'd0);
        check("rst_d_source", dSource, 3'd0);
        check("rst_d_data", dData, 64'd0);
        check("rst_err_timeout", errTimeout, 1'b0);

        doTxn(3'd4, 2'd3, 3'd3, 31'h100, 8'hFF, 64'h0, 1, 64'hDEAD_BEEF, 0);
        doTxn(3'd1, 2'd2, 3'd1, 31'h208, 8'h0F, 64'h1234, 0, 64'hAAAA_5555_AAAA_5555, 0);
        // Ack on the fourth REQ cycle: coincides with the watchdog terminal count when it is built in.
        doTxn(3'd0, 2'd3, 3'd6, 31'h7FFF_FFF8, 8'hFF, 64'h0123_4567_89AB_CDEF, 3, 64'h0, 5);
        doTxn(3'd3, 2'd1, 3'd2, 31'h40, 8'h03, 64'h55, 0, 64'h0, 2);
        doTxn(3'd4, 2'd2, 3'd7, 31'h7FFF_FFFC, 8'h00, 64'h0, 0, 64'hFFFF_0000_1234_5678, 0);

        regAck = 1'b1; regRdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick(); tick();
        regAck = 1'b0;
        check("idle_ack_no_d", dValid, 1'b0);
        check("idle_ack_no_req", reqValid, 1'b0);
        check("idle_ack_a_ready", aReady, 1'b1);

        aValid = 1'b1; aOpcode = 3'd4; aSize = 2'd3; aSource = 3'd5; aAddress = 31'h300;
        tick();
        aValid = 1'b0;
        check("pre_reset_req_valid", reqValid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_req_valid", reqValid, 1'b0);
        check("mid_reset_a_ready", aReady, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("mid_reset_no_d", dValid, 1'b0);
            tick();
        end

        doTxn(3'd4, 2'd1, 3'd4, 31'h18, 8'h00, 64'h0, 2, 64'h0000_0000_CAFE_F00D, 1);

`ifdef TL_REG_BRIDGE_TIMEOUT_EN
        begin
            dExpT e;
            e.op = 3'd1; e.size = 2'd3; e.src = 3'd2; e.data = {64{1'b1}};
            expQ.push_back(e);
            aValid = 1'b1; aOpcode = 3'd4; aSize = 2'd3; aSource = 3'd2; aAddress = 31'h500;
            tick();
            aValid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                check("to_req_valid", reqValid, 1'b1);
                check("to_err_before", errTimeout, 1'b0);
                tick();
            end
            check("to_req_dropped", reqValid, 1'b0);
            check("to_err_set", errTimeout, 1'b1);
            expectResp(0);
            check("to_err_sticky", errTimeout, 1'b1);
        end
`else
        check("err_timeout_tied_low", errTimeout, 1'b0);
`endif

        check("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
